monitor_contador_decrescente: RTL and testbench
===============================================

MONITOR_CONTADOR_DECRESCENTE -- requirements
Module: monitor_contador_decrescente

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset; all state SHALL change only on the rising edge of clk.
REQ-002 Port clk, input, 1 bit: single clock, shared with the upstream 4-bit down counter.
REQ-003 Port rst, input, 1 bit: synchronous active-high reset, the same net that resets the counter.
REQ-004 Port q, input, 4 bits: counter output, sampled every clk edge.
REQ-005 Port limpa, input, 1 bit: synchronous clear of the error flag and resync request.
REQ-006 Port seg, output, 7 bits: active-high segments {g,f,e,d,c,b,a} showing the hex digit of the last sample.
REQ-007 Port volta, output, 1 bit: one-cycle pulse marking a detected wrap from 0 to 15.
REQ-008 Port ciclos, output, 8 bits: count of wraps, modulo 256.
REQ-009 Port erro, output, 1 bit: sticky sequence-violation flag.
REQ-010 Port erros, output, 4 bits: count of violations, saturating at 15.
REQ-011 Port estado, output, 2 bits: current FSM state encoding.

Function
REQ-012 The module SHALL register q into q_r on every edge; seg SHALL be a combinational hex decode of q_r (1-cycle latency from q), covering 0-F.
REQ-013 The expected next value SHALL be esperado = (q_r - 1) mod 16, so 0 is expected to be followed by 15.
REQ-014 The FSM SHALL have three states: AGUARDA=0, RASTREIA=1, FALHA=2; encoding 3 is unused and SHALL return to AGUARDA.
REQ-015 In AGUARDA, the first sampled value SHALL only establish q_r, with no comparison, and the next state SHALL be RASTREIA; the counter's reset value is therefore irrelevant.
REQ-016 In RASTREIA, q == esperado SHALL keep the state unchanged.
REQ-017 In RASTREIA, q != esperado SHALL move to FALHA, set erro, and increment erros (no increment past 15).
REQ-018 In FALHA, sampling and seg update SHALL continue; no further comparisons, erros increments or volta pulses SHALL occur.
REQ-019 limpa=1 in any state SHALL clear erro and move to AGUARDA on that edge; erros and ciclos SHALL be preserved.
REQ-020 If limpa coincides with a mismatch, limpa SHALL win: no erro set, no erros increment.
REQ-021 volta SHALL be registered and high for exactly the one cycle after an edge where the state is RASTREIA, q_r==0 and q==15; ciclos SHALL increment on that same edge, wrapping 255->0.
REQ-022 A held q value in RASTREIA (e.g. 5 followed by 5) SHALL count as a mismatch.

Reset
REQ-023 With rst=1 at an edge, the module SHALL set state=AGUARDA, q_r=0 (seg shows "0" = 0111111), volta=0, ciclos=0, erro=0, erros=0.
REQ-024 rst SHALL take priority over limpa and over every FSM transition.
REQ-025 rst asserted mid-count SHALL be a clean restart: the counter's jump to its reset value SHALL never be reported as an error.

Structure
REQ-026 A shared package monitor_pkg SHALL hold the state encodings, the 16-entry segment table and width constants (W_Q=4, W_CICLOS=8, W_ERROS=4).
REQ-027 The hex-to-7-segment decode SHALL be a sub-module, decodificador_7seg (in: 4 bits, out: 7 bits, purely combinational).
REQ-028 The target size SHALL be roughly 120-250 lines of RTL in total.

Verification
REQ-029 Reset then count 15,14,...,0,15,14: erro=0, erros=0, one volta pulse, ciclos=1, seg tracks q one cycle late (q=9 -> seg=1101111).
REQ-030 Reset mid-count when q reaches 3: all outputs return to reset values; after restart, counting continues with erro=0.
REQ-031 Inject sequence 7,6,4: erro=1 and erros=1 one cycle after the 4 is sampled; state=FALHA; no volta while in FALHA.
REQ-032 Pulse limpa in FALHA, then resume a legal count: erro=0, state AGUARDA then RASTREIA, erros stays 1.
REQ-033 Inject 16 violations, each separated by limpa: erros saturates at 15.
REQ-034 Apply limpa on the same edge as a mismatch: erro stays 0, erros unchanged. Run 256 full wraps: ciclos wraps to 0.

Source files
------------

// File: rtl/monitor_pkg.sv
// Purpose: shared definitions for the down-counter monitor: FSM state
// encodings, width constants and the hex-to-7-segment table.
// Ports: none (package).
package monitor_pkg;

    localparam int unsigned W_Q      = 4;
    localparam int unsigned W_CICLOS = 8;
    localparam int unsigned W_ERROS  = 4;
    localparam int unsigned W_SEG    = 7;
    localparam int unsigned W_ESTADO = 2;

    localparam logic [W_ERROS-1:0] ERROS_MAX = W_ERROS'(15);

    typedef enum logic [W_ESTADO-1:0] {
        AGUARDA  = 2'd0,
        RASTREIA = 2'd1,
        FALHA    = 2'd2
    } estado_t;

    // Active-high segments ordered {g,f,e,d,c,b,a}, indexed by hex digit.
    localparam logic [W_SEG-1:0] SEG_TABLE [16] = '{
        7'b0111111, // 0
        7'b0000110, // 1
        7'b1011011, // 2
        7'b1001111, // 3
        7'b1100110, // 4
        7'b1101101, // 5
        7'b1111101, // 6
        7'b0000111, // 7
        7'b1111111, // 8
        7'b1101111, // 9
        7'b1110111, // A
        7'b1111100, // b
        7'b0111001, // C
        7'b1011110, // d
        7'b1111001, // E
        7'b1110001  // F
    };

endpackage

// File: rtl/decodificador_7seg.sv
// Purpose: purely combinational hex digit to 7-segment decode.
// Ports:
//   i_hex : 4-bit hex digit
//   o_seg : active-high segments {g,f,e,d,c,b,a}
module decodificador_7seg
    import monitor_pkg::*;
(
    input  logic [W_Q-1:0]   i_hex,
    output logic [W_SEG-1:0] o_seg
);

    assign o_seg = SEG_TABLE[i_hex];

endmodule

// File: rtl/monitor_contador_decrescente.sv
// Purpose: watches a 4-bit down counter, flags sequence violations,
// counts 0->15 wraps and shows the last sample on a 7-segment display.
// Ports:
//   clk    : clock shared with the counter
//   rst    : synchronous active-high reset
//   q      : counter value, sampled every edge
//   limpa  : clears erro and requests resync (back to AGUARDA)
//   seg    : 7-segment decode of the last sample (combinational from q_r)
//   volta  : one-cycle pulse after a detected 0->15 wrap
//   ciclos : wrap count, modulo 256
//   erro   : sticky violation flag
//   erros  : violation count, saturating at 15
//   estado : current FSM state
module monitor_contador_decrescente
    import monitor_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [W_Q-1:0]        q,
    input  logic                  limpa,
    output logic [W_SEG-1:0]      seg,
    output logic                  volta,
    output logic [W_CICLOS-1:0]   ciclos,
    output logic                  erro,
    output logic [W_ERROS-1:0]    erros,
    output logic [W_ESTADO-1:0]   estado
);

    estado_t               r_state;
    logic [W_Q-1:0]        r_q;
    logic                  r_volta;
    logic [W_CICLOS-1:0]   r_ciclos;
    logic                  r_erro;
    logic [W_ERROS-1:0]    r_erros;

    estado_t               w_state_nx;
    logic                  w_volta_nx;
    logic [W_CICLOS-1:0]   w_ciclos_nx;
    logic                  w_erro_nx;
    logic [W_ERROS-1:0]    w_erros_nx;
    logic [W_Q-1:0]        w_esperado;
    logic                  w_wrap;

    // Expected successor of the last sample; 0 wraps to 15.
    assign w_esperado = r_q - W_Q'(1);
    assign w_wrap     = (r_state == RASTREIA) && (r_q == W_Q'(0)) && (q == W_Q'(15));

    // State register and sampled value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= AGUARDA;
            r_q      <= '0;
            r_volta  <= 1'b0;
            r_ciclos <= '0;
            r_erro   <= 1'b0;
            r_erros  <= '0;
        end else begin
            r_state  <= w_state_nx;
            r_q      <= q;
            r_volta  <= w_volta_nx;
            r_ciclos <= w_ciclos_nx;
            r_erro   <= w_erro_nx;
            r_erros  <= w_erros_nx;
        end
    end

    // Next-state and output logic; limpa overrides any comparison result.
    always_comb begin
        w_state_nx  = r_state;
        w_volta_nx  = 1'b0;
        w_ciclos_nx = r_ciclos;
        w_erro_nx   = r_erro;
        w_erros_nx  = r_erros;

        // A wrap is a legal step, so it is independent of limpa.
        if (w_wrap) begin
            w_volta_nx  = 1'b1;
            w_ciclos_nx = r_ciclos + W_CICLOS'(1);
        end

        if (limpa) begin
            w_state_nx = AGUARDA;
            w_erro_nx  = 1'b0;
        end else begin
            case (r_state)
                AGUARDA: begin
                    // First sample only seeds r_q.
                    w_state_nx = RASTREIA;
                end
                RASTREIA: begin
                    if (q != w_esperado) begin
                        w_state_nx = FALHA;
                        w_erro_nx  = 1'b1;
                        if (r_erros != ERROS_MAX) begin
                            w_erros_nx = r_erros + W_ERROS'(1);
                        end
                    end
                end
                FALHA: begin
                    w_state_nx = FALHA;
                end
                default: begin
                    w_state_nx = AGUARDA;
                end
            endcase
        end
    end

    decodificador_7seg u_dec (
        .i_hex (r_q),
        .o_seg (seg)
    );

    assign volta  = r_volta;
    assign ciclos = r_ciclos;
    assign erro   = r_erro;
    assign erros  = r_erros;
    assign estado = r_state;

endmodule

// File: tb/tb_monitor_contador_decrescente.sv
// Purpose: directed self-checking bench for monitor_contador_decrescente.
module tb_monitor_contador_decrescente;

    logic       clk;
    logic       rst;
    logic [3:0] q;
    logic       limpa;
    logic [6:0] seg;
    logic       volta;
    logic [7:0] ciclos;
    logic       erro;
    logic [3:0] erros;
    logic [1:0] estado;

    int n_checks;
    int n_errors;

    logic [6:0] seg_ref [16];

    monitor_contador_decrescente dut (
        .clk    (clk),
        .rst    (rst),
        .q      (q),
        .limpa  (limpa),
        .seg    (seg),
        .volta  (volta),
        .ciclos (ciclos),
        .erro   (erro),
        .erros  (erros),
        .estado (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [3:0] v, input logic l);
        q     = v;
        limpa = l;
        tick();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        limpa = 1'b0;
        q     = 4'd7;
        tick();
        rst   = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (estado !== 2'd0) begin n_errors++; $display("FAIL reset_estado got %0d exp 0", estado); end
        n_checks++;
        if (seg !== 7'b0111111) begin n_errors++; $display("FAIL reset_seg got %b exp 0111111", seg); end
        n_checks++;
        if ({volta, erro} !== 2'b00) begin n_errors++; $display("FAIL reset_flags got %b exp 00", {volta, erro}); end
        n_checks++;
        if (ciclos !== 8'd0 || erros !== 4'd0) begin
            n_errors++; $display("FAIL reset_counts got ciclos=%0d erros=%0d exp 0 0", ciclos, erros);
        end
    endtask

    task automatic test_count();
        int pulses;
        int seg_bad;
        logic [3:0] v;
        pulses  = 0;
        seg_bad = 0;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            v = 4'(15 - (i % 16));
            feed(v, 1'b0);
            if (seg !== seg_ref[v]) seg_bad++;
            if (volta === 1'b1) pulses++;
            if (i == 0) begin
                n_checks++;
                if (estado !== 2'd1) begin n_errors++; $display("FAIL count_first_state got %0d exp 1", estado); end
            end
            if (v == 4'd9) begin
                n_checks++;
                if (seg !== 7'b1101111) begin n_errors++; $display("FAIL count_seg9 got %b exp 1101111", seg); end
            end
            if (i == 16) begin
                n_checks++;
                if (volta !== 1'b1) begin n_errors++; $display("FAIL count_volta_edge got %b exp 1", volta); end
            end
        end
        n_checks++;
        if (seg_bad != 0) begin n_errors++; $display("FAIL count_seg_track got %0d bad exp 0", seg_bad); end
        n_checks++;
        if (pulses != 1) begin n_errors++; $display("FAIL count_volta_pulses got %0d exp 1", pulses); end
        n_checks++;
        if (ciclos !== 8'd1) begin n_errors++; $display("FAIL count_ciclos got %0d exp 1", ciclos); end
        n_checks++;
        if (erro !== 1'b0 || erros !== 4'd0 || estado !== 2'd1) begin
            n_errors++; $display("FAIL count_clean got erro=%b erros=%0d estado=%0d exp 0 0 1", erro, erros, estado);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        do_reset();
        for (int v = 15; v >= 4; v--) feed(4'(v), 1'b0);
        // Counter and monitor reset together while the counter shows 3.
        rst = 1'b1;
        feed(4'd3, 1'b0);
        rst = 1'b0;
        n_checks++;
        if (estado !== 2'd0 || seg !== 7'b0111111 || volta !== 1'b0 || ciclos !== 8'd0
            || erro !== 1'b0 || erros !== 4'd0) begin
            n_errors++;
            $display("FAIL mid_reset got estado=%0d seg=%b volta=%b ciclos=%0d erro=%b erros=%0d exp 0 0111111 0 0 0 0",
                     estado, seg, volta, ciclos, erro, erros);
        end
        // Counter restarts from its reset value 0.
        pulses = 0;
        feed(4'd0, 1'b0);
        feed(4'd15, 1'b0); if (volta === 1'b1) pulses++;
        feed(4'd14, 1'b0); if (volta === 1'b1) pulses++;
        feed(4'd13, 1'b0); if (volta === 1'b1) pulses++;
        n_checks++;
        if (erro !== 1'b0 || estado !== 2'd1) begin
            n_errors++; $display("FAIL mid_restart got erro=%b estado=%0d exp 0 1", erro, estado);
        end
        n_checks++;
        if (pulses != 1 || ciclos !== 8'd1) begin
            n_errors++; $display("FAIL mid_wrap got pulses=%0d ciclos=%0d exp 1 1", pulses, ciclos);
        end
    endtask

    task automatic test_violation();
        int pulses;
        do_reset();
        feed(4'd7, 1'b0);
        feed(4'd6, 1'b0);
        n_checks++;
        if (erro !== 1'b0) begin n_errors++; $display("FAIL viol_before got erro=%b exp 0", erro); end
        feed(4'd4, 1'b0);
        n_checks++;
        if (erro !== 1'b1 || erros !== 4'd1 || estado !== 2'd2) begin
            n_errors++; $display("FAIL viol_detect got erro=%b erros=%0d estado=%0d exp 1 1 2", erro, erros, estado);
        end
        // In FALHA a 0->15 step must not pulse volta nor count.
        pulses = 0;
        feed(4'd0, 1'b0);  if (volta === 1'b1) pulses++;
        feed(4'd15, 1'b0); if (volta === 1'b1) pulses++;
        feed(4'd9, 1'b0);  if (volta === 1'b1) pulses++;
        n_checks++;
        if (pulses != 0 || ciclos !== 8'd0 || erros !== 4'd1 || estado !== 2'd2) begin
            n_errors++; $display("FAIL viol_falha got pulses=%0d ciclos=%0d erros=%0d estado=%0d exp 0 0 1 2",
                                 pulses, ciclos, erros, estado);
        end
        n_checks++;
        if (seg !== 7'b1101111) begin n_errors++; $display("FAIL viol_seg got %b exp 1101111", seg); end
    endtask

    task automatic test_limpa();
        // Continues from the FALHA state left by test_violation.
        feed(4'd8, 1'b1);
        n_checks++;
        if (erro !== 1'b0 || estado !== 2'd0 || erros !== 4'd1) begin
            n_errors++; $display("FAIL limpa_clear got erro=%b estado=%0d erros=%0d exp 0 0 1", erro, estado, erros);
        end
        feed(4'd7, 1'b0);
        n_checks++;
        if (estado !== 2'd1) begin n_errors++; $display("FAIL limpa_resync got %0d exp 1", estado); end
        feed(4'd6, 1'b0);
        feed(4'd5, 1'b0);
        n_checks++;
        if (erro !== 1'b0 || erros !== 4'd1 || estado !== 2'd1) begin
            n_errors++; $display("FAIL limpa_resume got erro=%b erros=%0d estado=%0d exp 0 1 1", erro, erros, estado);
        end
    endtask

    task automatic test_saturation();
        int bad;
        bad = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            feed(4'd5, 1'b0);
            feed(4'd5, 1'b0);   // held value is a violation
            if (erro !== 1'b1 || erros !== 4'((i + 1 > 15) ? 15 : i + 1)) bad++;
            feed(4'd5, 1'b1);
        end
        n_checks++;
        if (bad != 0) begin n_errors++; $display("FAIL sat_steps got %0d bad steps exp 0", bad); end
        n_checks++;
        if (erros !== 4'd15 || erro !== 1'b0) begin
            n_errors++; $display("FAIL sat_final got erros=%0d erro=%b exp 15 0", erros, erro);
        end
    endtask

    task automatic test_limpa_mismatch();
        do_reset();
        feed(4'd8, 1'b0);
        feed(4'd2, 1'b1);
        n_checks++;
        if (erro !== 1'b0 || erros !== 4'd0 || estado !== 2'd0) begin
            n_errors++; $display("FAIL limpa_wins got erro=%b erros=%0d estado=%0d exp 0 0 0", erro, erros, estado);
        end
    endtask

    task automatic test_wraps();
        do_reset();
        for (int w = 0; w < 256; w++) begin
            for (int v = 15; v >= 0; v--) feed(4'(v), 1'b0);
        end
        n_checks++;
        if (ciclos !== 8'd255) begin n_errors++; $display("FAIL wraps_255 got %0d exp 255", ciclos); end
        feed(4'd15, 1'b0);
        n_checks++;
        if (ciclos !== 8'd0 || volta !== 1'b1) begin
            n_errors++; $display("FAIL wraps_roll got ciclos=%0d volta=%b exp 0 1", ciclos, volta);
        end
        feed(4'd14, 1'b0);
        n_checks++;
        if (volta !== 1'b0 || erro !== 1'b0 || erros !== 4'd0) begin
            n_errors++; $display("FAIL wraps_end got volta=%b erro=%b erros=%0d exp 0 0 0", volta, erro, erros);
        end
    endtask

    initial begin
        seg_ref = '{7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
                    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
                    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
                    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001};
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        limpa    = 1'b0;
        q        = 4'd0;
        test_reset();
        test_count();
        test_reset_mid();
        test_violation();
        test_limpa();
        test_saturation();
        test_limpa_mismatch();
        test_wraps();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
